// File: rtl/chacha20_mem_arbiter.sv
// Two-requester arbiter (CPU = 0, ChaCha20 engine = 1) for a single-port byte RAM with
// registered address, supporting locked bursts and fully pipelined single-cycle reads.
module chacha20_mem_arbiter #(
   parameter int ADDR_W   = 14,
   parameter int DATA_W   = 8,
   parameter int LOCK_MAX = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_address,
   input  logic [DATA_W-1:0] req0_writedata,
   input  logic              req0_lock,
   output logic              req0_ready,
   output logic              req0_rdvalid,
   output logic [DATA_W-1:0] req0_readdata,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_address,
   input  logic [DATA_W-1:0] req1_writedata,
   input  logic              req1_lock,
   output logic              req1_ready,
   output logic              req1_rdvalid,
   output logic [DATA_W-1:0] req1_readdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_debugaccess,
   input  logic [DATA_W-1:0] mem_readdata
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   typedef enum logic [1:0] {
      UNLOCKED,
      LOCK0,
      LOCK1
   } lock_e;

   lock_e             state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic              last_grant_q, last_grant_d;
   logic              rd_pend_q, rd_id_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;

   logic              gnt0, gnt1, accept, win_id, win_write, win_lock;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   // Grants are forced low during reset so every output reads 0 while it is held.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         case (state_q)
            UNLOCKED: begin
               if (req0_valid && req1_valid) begin
                  gnt0 = last_grant_q;
                  gnt1 = !last_grant_q;
               end else begin
                  gnt0 = req0_valid;
                  gnt1 = req1_valid;
               end
            end
            LOCK0:   gnt0 = req0_valid;
            LOCK1:   gnt1 = req1_valid;
            default: ;
         endcase
      end
   end

   assign accept    = gnt0 | gnt1;
   assign win_id    = gnt1;
   assign win_write = gnt1 ? req1_write     : req0_write;
   assign win_lock  = gnt1 ? req1_lock      : req0_lock;
   assign win_addr  = gnt1 ? req1_address   : req0_address;
   assign win_wdata = gnt1 ? req1_writedata : req0_writedata;
   assign cnt_inc   = cnt_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      if (accept) begin
         last_grant_d = win_id;
         if (win_lock && (cnt_inc < CNT_W'(LOCK_MAX))) begin
            state_d = win_id ? LOCK1 : LOCK0;
            cnt_d   = cnt_inc;
         end else begin
            state_d = UNLOCKED;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= UNLOCKED;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Read return path: the RAM answers one cycle after the accepted address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pend_q <= 1'b0;
         rd_id_q   <= 1'b0;
         addr_q    <= '0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         rd_pend_q <= accept & ~win_write;
         if (accept) begin
            rd_id_q <= win_id;
            addr_q  <= win_addr;
         end
         if (req0_rdvalid) rdata0_q <= mem_readdata;
         if (req1_rdvalid) rdata1_q <= mem_readdata;
      end
   end

   assign req0_ready      = gnt0;
   assign req1_ready      = gnt1;
   assign req0_rdvalid    = rd_pend_q & ~rd_id_q;
   assign req1_rdvalid    = rd_pend_q &  rd_id_q;
   assign req0_readdata   = req0_rdvalid ? mem_readdata : rdata0_q;
   assign req1_readdata   = req1_rdvalid ? mem_readdata : rdata1_q;
   assign mem_chipselect  = accept;
   assign mem_write       = accept & win_write;
   assign mem_debugaccess = mem_write;
   assign mem_address     = accept ? win_addr : addr_q;
   assign mem_writedata   = accept ? win_wdata : '0;

endmodule

// File: tb/tb_chacha20_mem_arbiter.sv
// Scoreboard bench for chacha20_mem_arbiter: stimulus queues expected grants and read
// returns, a negedge monitor pops and compares them whenever the DUT presents one.
module tb_chacha20_mem_arbiter;

   logic        clk, reset;
   logic        req0_valid, req0_write, req0_lock;
   logic [13:0] req0_address;
   logic [7:0]  req0_writedata;
   logic        req0_ready, req0_rdvalid;
   logic [7:0]  req0_readdata;
   logic        req1_valid, req1_write, req1_lock;
   logic [13:0] req1_address;
   logic [7:0]  req1_writedata;
   logic        req1_ready, req1_rdvalid;
   logic [7:0]  req1_readdata;
   logic [13:0] mem_address;
   logic        mem_chipselect, mem_write, mem_debugaccess;
   logic [7:0]  mem_writedata, mem_readdata;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        id;
      logic        wr;
      logic [13:0] addr;
      logic [7:0]  wd;
   } gexp_t;

   typedef struct {
      logic       id;
      logic [7:0] data;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];

   chacha20_mem_arbiter #(.ADDR_W(14), .DATA_W(8), .LOCK_MAX(64)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_address(req0_address),
      .req0_writedata(req0_writedata), .req0_lock(req0_lock), .req0_ready(req0_ready),
      .req0_rdvalid(req0_rdvalid), .req0_readdata(req0_readdata),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_address(req1_address),
      .req1_writedata(req1_writedata), .req1_lock(req1_lock), .req1_ready(req1_ready),
      .req1_rdvalid(req1_rdvalid), .req1_readdata(req1_readdata),
      .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_debugaccess(mem_debugaccess),
      .mem_readdata(mem_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: registered address, unregistered read data.
   logic [7:0]  ram [0:16383];
   logic [13:0] ram_addr_q;
   initial begin
      for (int i = 0; i < 16384; i++) ram[i] = 8'h00;
      ram[14'h0010] = 8'h3C;
      ram[14'h0020] = 8'h7E;
      ram_addr_q    = 14'h0;
   end
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write) ram[mem_address] <= mem_writedata;
         ram_addr_q <= mem_address;
      end
   end
   assign mem_readdata = ram[ram_addr_q];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic exp_grant(input logic id, input logic wr, input logic [13:0] a,
                            input logic [7:0] d);
      gexp_t g;
      g.id = id; g.wr = wr; g.addr = a; g.wd = d;
      gq.push_back(g);
   endtask

   task automatic exp_rd(input logic id, input logic [7:0] d);
      rexp_t r;
      r.id = id; r.data = d;
      rq.push_back(r);
   endtask

   task automatic set0(input logic v, input logic w, input logic [13:0] a,
                       input logic [7:0] d, input logic l);
      req0_valid = v; req0_write = w; req0_address = a; req0_writedata = d; req0_lock = l;
   endtask

   task automatic set1(input logic v, input logic w, input logic [13:0] a,
                       input logic [7:0] d, input logic l);
      req1_valid = v; req1_write = w; req1_address = a; req1_writedata = d; req1_lock = l;
   endtask

   task automatic idle();
      set0(1'b0, 1'b0, 14'h0, 8'h0, 1'b0);
      set1(1'b0, 1'b0, 14'h0, 8'h0, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string name);
      chk(name, {19'h0, req0_ready, req1_ready, req0_rdvalid, req1_rdvalid, req0_readdata,
                 req1_readdata, mem_address, mem_chipselect, mem_write, mem_writedata,
                 mem_debugaccess}, 64'h0);
   endtask

   // Monitor
   always @(negedge clk) begin
      gexp_t g;
      rexp_t r;
      if (req0_ready || req1_ready) begin
         chk("ready_onehot", {63'h0, req0_ready & req1_ready}, 64'h0);
         if (gq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL grant_unexpected: got ready0=%0b ready1=%0b, required no grant",
                     req0_ready, req1_ready);
         end else begin
            g = gq.pop_front();
            chk("grant_id", {63'h0, req1_ready}, {63'h0, g.id});
            chk("mem_cs", {63'h0, mem_chipselect}, 64'h1);
            chk("mem_write", {63'h0, mem_write}, {63'h0, g.wr});
            chk("mem_debugaccess", {63'h0, mem_debugaccess}, {63'h0, g.wr});
            chk("mem_address", {50'h0, mem_address}, {50'h0, g.addr});
            if (g.wr) chk("mem_writedata", {56'h0, mem_writedata}, {56'h0, g.wd});
         end
      end else begin
         chk("idle_cs", {63'h0, mem_chipselect}, 64'h0);
         chk("idle_write", {63'h0, mem_write}, 64'h0);
      end
      if (req0_rdvalid || req1_rdvalid) begin
         chk("rdvalid_onehot", {63'h0, req0_rdvalid & req1_rdvalid}, 64'h0);
         if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rdvalid_unexpected: got rdvalid0=%0b rdvalid1=%0b, required none",
                     req0_rdvalid, req1_rdvalid);
         end else begin
            r = rq.pop_front();
            chk("rd_id", {63'h0, req1_rdvalid}, {63'h0, r.id});
            chk("rd_data", {56'h0, (r.id ? req1_readdata : req0_readdata)}, {56'h0, r.data});
         end
      end
   end

   initial begin
      reset = 1'b1;
      set0(1'b1, 1'b0, 14'h0010, 8'h0, 1'b0);
      set1(1'b1, 1'b0, 14'h0020, 8'h0, 1'b0);
      repeat (2) step();
      chk_reset_outputs("reset_outputs");
      idle();
      reset = 1'b0;
      step();

      // Both read every cycle: grants alternate starting with the CPU.
      set0(1'b1, 1'b0, 14'h0010, 8'h0, 1'b0);
      set1(1'b1, 1'b0, 14'h0020, 8'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) begin
            exp_grant(1'b0, 1'b0, 14'h0010, 8'h0);
            exp_rd(1'b0, 8'h3C);
         end else begin
            exp_grant(1'b1, 1'b0, 14'h0020, 8'h0);
            exp_rd(1'b1, 8'h7E);
         end
         step();
      end
      idle();
      repeat (2) step();

      // Engine write then CPU read-back of the top address.
      set1(1'b1, 1'b1, 14'h3FFF, 8'hA5, 1'b0);
      exp_grant(1'b1, 1'b1, 14'h3FFF, 8'hA5);
      step();
      set1(1'b0, 1'b0, 14'h0, 8'h0, 1'b0);
      set0(1'b1, 1'b0, 14'h3FFF, 8'h0, 1'b0);
      exp_grant(1'b0, 1'b0, 14'h3FFF, 8'h0);
      exp_rd(1'b0, 8'hA5);
      step();
      idle();
      repeat (3) step();
      chk("hold_readdata0", {56'h0, req0_readdata}, 64'hA5);
      chk("hold_readdata1", {56'h0, req1_readdata}, 64'h7E);

      // 64-write locked engine burst with the CPU waiting throughout.
      set0(1'b1, 1'b0, 14'h0010, 8'h0, 1'b0);
      for (int i = 0; i < 64; i++) begin
         set1(1'b1, 1'b1, 14'h0100 + 14'(i), 8'(i), 1'b1);
         exp_grant(1'b1, 1'b1, 14'h0100 + 14'(i), 8'(i));
         step();
      end
      set1(1'b1, 1'b1, 14'h0200, 8'h55, 1'b1);
      exp_grant(1'b0, 1'b0, 14'h0010, 8'h0);
      exp_rd(1'b0, 8'h3C);
      step();
      idle();
      repeat (2) step();
      set0(1'b1, 1'b0, 14'h013F, 8'h0, 1'b0);
      exp_grant(1'b0, 1'b0, 14'h013F, 8'h0);
      exp_rd(1'b0, 8'h3F);
      step();
      idle();
      repeat (2) step();

      // Lock held across an engine idle gap; released only by a lock=0 transfer.
      set1(1'b1, 1'b1, 14'h0300, 8'h11, 1'b1);
      exp_grant(1'b1, 1'b1, 14'h0300, 8'h11);
      step();
      set1(1'b0, 1'b0, 14'h0, 8'h0, 1'b0);
      set0(1'b1, 1'b0, 14'h0020, 8'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("lock_gap_ready0", {63'h0, req0_ready}, 64'h0);
         chk("lock_gap_addr_hold", {50'h0, mem_address}, 64'h0300);
         step();
      end
      set1(1'b1, 1'b1, 14'h0301, 8'h22, 1'b1);
      exp_grant(1'b1, 1'b1, 14'h0301, 8'h22);
      step();
      set1(1'b1, 1'b1, 14'h0302, 8'h33, 1'b0);
      exp_grant(1'b1, 1'b1, 14'h0302, 8'h33);
      step();
      set1(1'b1, 1'b1, 14'h0303, 8'h44, 1'b0);
      exp_grant(1'b0, 1'b0, 14'h0020, 8'h0);
      exp_rd(1'b0, 8'h7E);
      step();
      idle();
      repeat (2) step();
      chk("hold_readdata0_b", {56'h0, req0_readdata}, 64'h7E);

      // Reset the cycle after an accepted CPU read: the read is discarded.
      set0(1'b1, 1'b0, 14'h0010, 8'h0, 1'b0);
      exp_grant(1'b0, 1'b0, 14'h0010, 8'h0);
      step();
      reset = 1'b1;
      set1(1'b1, 1'b0, 14'h0020, 8'h0, 1'b0);
      #1;
      chk_reset_outputs("reset_mid_read_outputs");
      repeat (2) step();
      idle();
      reset = 1'b0;
      step();
      set0(1'b1, 1'b0, 14'h0010, 8'h0, 1'b0);
      set1(1'b1, 1'b0, 14'h0020, 8'h0, 1'b0);
      exp_grant(1'b0, 1'b0, 14'h0010, 8'h0);
      exp_rd(1'b0, 8'h3C);
      step();
      idle();
      repeat (2) step();

      // Reset mid-burst clears the lock.
      set1(1'b1, 1'b1, 14'h0304, 8'h66, 1'b1);
      exp_grant(1'b1, 1'b1, 14'h0304, 8'h66);
      step();
      reset = 1'b1;
      idle();
      step();
      reset = 1'b0;
      step();
      set0(1'b1, 1'b0, 14'h0010, 8'h0, 1'b0);
      set1(1'b1, 1'b0, 14'h0020, 8'h0, 1'b0);
      exp_grant(1'b0, 1'b0, 14'h0010, 8'h0);
      exp_rd(1'b0, 8'h3C);
      step();
      idle();
      repeat (3) step();

      chk("grant_queue_drained", 64'(gq.size()), 64'h0);
      chk("read_queue_drained", 64'(rq.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/chacha20_mem_arbiter.md
CHACHA20_MEM_ARBITER -- requirements
Module: chacha20_mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 14, memory word-address width (16384 bytes).
- DATA_W, 8, memory data width.
- LOCK_MAX, 64, maximum accepted transfers per locked burst.
REQ-002 clk  input  1  single clock; all state on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0 CPU, N=1 ChaCha20 engine) has a transfer pending.
REQ-005 reqN_write  input  1  1=write, 0=read.
REQ-006 reqN_address  input  ADDR_W  byte address.
REQ-007 reqN_writedata  input  DATA_W  write byte.
REQ-008 reqN_lock  input  1  keep grant after this transfer.
REQ-009 reqN_ready  output  1  transfer accepted this cycle; transfer occurs when valid&ready.
REQ-010 reqN_rdvalid  output  1  one-cycle pulse, read data valid.
REQ-011 reqN_readdata  output  DATA_W  read byte, qualified by rdvalid.
REQ-012 mem_address  output  ADDR_W  to RAM (RAM registers address; read data appears next cycle).
REQ-013 mem_chipselect  output  1  RAM select.
REQ-014 mem_write  output  1  RAM write enable.
REQ-015 mem_writedata  output  DATA_W  RAM write byte.
REQ-016 mem_debugaccess  output  1  held 1 whenever mem_write=1 so RAM write gating passes.
REQ-017 mem_readdata  input  DATA_W  unregistered RAM output.

Function
REQ-018 At most one reqN_ready SHALL be high per cycle; ready is combinational from valid, lock state and last_grant.
REQ-019 The winner SHALL be chosen by lock state, UNLOCKED, LOCK0 or LOCK1:
- UNLOCKED: single valid requester wins; if both are valid, the requester != last_grant wins.
- LOCKn: only requester n is eligible; the other ready stays 0 even if n is idle.
REQ-020 mem_chipselect SHALL equal (any ready); mem_address, mem_write and mem_writedata SHALL mux from the winner in the same cycle.
- With no winner: mem_write=0 and mem_address holds its last value.
REQ-021 last_grant SHALL update to the winner on every accepted transfer.
REQ-022 Lock state transitions on an accepted transfer by n:
- lock=1: go to or stay in LOCKn and increment lock_cnt.
- lock=0: go to UNLOCKED and clear lock_cnt.
REQ-023 When lock_cnt reaches LOCK_MAX on an accepted transfer, the state SHALL go to UNLOCKED regardless of lock.
- lock_cnt clears.
- The other requester wins the next tie.
REQ-024 An accepted read SHALL set rd_pend=1 and rd_id=n; the next cycle, reqN_rdvalid=1 for rd_id with readdata=mem_readdata.
- Read latency is exactly 1 cycle.
- Reads are fully pipelined (back-to-back accepted reads return back-to-back).
REQ-025 Writes SHALL produce no rdvalid.
REQ-026 reqN_readdata SHALL hold its last returned value between pulses.
REQ-027 A read returning in the same cycle that a new transfer is accepted SHALL return correctly to its own rd_id.
REQ-028 Deasserting valid while in LOCKn SHALL NOT release the lock; only REQ-022/REQ-023 release it.

Reset
REQ-029 While reset is high, every output SHALL be 0, including all ready and rdvalid signals and mem_chipselect.
REQ-030 Reset SHALL clear the internal state:
- lock state=UNLOCKED, lock_cnt=0, rd_pend=0.
- last_grant=1, so the CPU wins the first tie.
REQ-031 Reset mid-burst or with a read outstanding SHALL discard the read: no rdvalid after release.

Verification
REQ-032 Out of reset, both request read @0x0010/0x0020 every cycle -> grants alternate 0,1,0,1; rdvalid each cycle after acceptance to the matching requester.
REQ-033 Engine writes 0xA5 @0x3FFF lock=0, then CPU reads 0x3FFF -> CPU readdata=0xA5 one cycle after its ready.
REQ-034 Engine burst of 64 writes with lock=1 while CPU holds valid -> CPU ready=0 for all 64; forced release; CPU granted on cycle 65.
REQ-035 Engine in LOCK1 drops valid for 3 cycles, CPU valid -> CPU ready stays 0; engine resumes, final transfer lock=0 -> CPU granted next cycle.
REQ-036 Reset asserted the cycle after an accepted CPU read -> no rdvalid; all outputs 0; state UNLOCKED; first post-reset tie goes to CPU.
